// File: rtl/timer_scheduler.sv
// Round-robin sharing of one one-shot hardware timer among N_CH requesters.
// Each channel queues a single delay request; the FSM programs, starts and retires the timer.
module timer_scheduler #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [16*N_CH-1:0]   req_load,
  input  logic [3*N_CH-1:0]    req_ps,
  input  logic [N_CH-1:0]      cancel,
  output logic [N_CH-1:0]      done,
  output logic [N_CH-1:0]      req_err,
  output logic [N_CH-1:0]      pending,
  output logic                 busy,
  output logic [CH_W-1:0]      active_ch,
  output logic [15:0]          tmr_load,
  output logic [2:0]           tmr_ps,
  output logic                 tmr_en,
  output logic                 tmr_go,
  output logic                 tmr_auto_load,
  output logic                 tmr_write,
  input  logic                 tmr_int,
  input  logic                 tmr_go_clear
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_RUN, S_WAIT, S_DONE} state_t;

  state_t                  state_q;
  logic [CH_W-1:0]         rr_q, active_q;
  logic [N_CH-1:0]         pending_q, done_q, req_err_q;
  logic [N_CH-1:0][15:0]   load_q;
  logic [N_CH-1:0][2:0]    ps_q;
  logic [15:0]             tmr_load_q;
  logic [2:0]              tmr_ps_q;
  logic                    busy_q, en_q, go_q, wr_q, int_q;

  logic [N_CH-1:0]         act_vec, avail;
  logic [CH_W-1:0]         grant;
  logic                    grant_vld, int_rise, cancel_act;

  assign int_rise   = tmr_int & ~int_q;
  assign cancel_act = (state_q != S_IDLE) && cancel[active_q];

  always_comb begin
    act_vec = '0;
    if (state_q != S_IDLE) act_vec[active_q] = 1'b1;
  end

  // A channel cancelled in the grant cycle must not be granted.
  always_comb begin
    avail     = pending_q & ~cancel;
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < N_CH; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % N_CH;
      if (!grant_vld && avail[idx]) begin
        grant_vld = 1'b1;
        grant     = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      done_q     <= '0;
      req_err_q  <= '0;
      load_q     <= '0;
      ps_q       <= '0;
      tmr_load_q <= '0;
      tmr_ps_q   <= '0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      go_q       <= 1'b0;
      wr_q       <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      done_q    <= '0;
      req_err_q <= '0;
      wr_q      <= 1'b0;
      int_q     <= tmr_int;

      for (int i = 0; i < N_CH; i++) begin
        if (cancel[i]) begin
          pending_q[i] <= 1'b0;
        end else if (req[i]) begin
          if (pending_q[i] || act_vec[i]) begin
            req_err_q[i] <= 1'b1;
          end else begin
            pending_q[i] <= 1'b1;
            load_q[i]    <= req_load[16*i +: 16];
            ps_q[i]      <= req_ps[3*i +: 3];
          end
        end
      end

      case (state_q)
        S_IDLE: if (grant_vld) begin
          pending_q[grant] <= 1'b0;
          active_q         <= grant;
          rr_q             <= (grant == CH_W'(N_CH-1)) ? '0 : grant + CH_W'(1);
          tmr_load_q       <= load_q[grant];
          tmr_ps_q         <= ps_q[grant];
          en_q             <= 1'b1;
          wr_q             <= 1'b1;
          busy_q           <= 1'b1;
          state_q          <= S_CFG;
        end
        S_CFG: begin
          go_q    <= 1'b1;
          state_q <= S_START;
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (int_rise) begin
            go_q             <= 1'b0;
            en_q             <= 1'b0;
            done_q[active_q] <= 1'b1;
            state_q          <= S_DONE;
          end else if (tmr_go_clear) begin
            go_q    <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: if (int_rise) begin
          en_q             <= 1'b0;
          done_q[active_q] <= 1'b1;
          state_q          <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Cancelling the owner abandons the job outright, overriding any completion.
      if (cancel_act) begin
        state_q <= S_IDLE;
        en_q    <= 1'b0;
        go_q    <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= '0;
      end
    end
  end

  assign done          = done_q;
  assign req_err       = req_err_q;
  assign pending       = pending_q;
  assign busy          = busy_q;
  assign active_ch     = active_q;
  assign tmr_load      = tmr_load_q;
  assign tmr_ps        = tmr_ps_q;
  assign tmr_en        = en_q;
  assign tmr_go        = go_q;
  assign tmr_auto_load = 1'b0;
  assign tmr_write     = wr_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler; the timer handshake is driven by hand with fixed timing.
module tb_timer_scheduler;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic              clk, rst;
  logic [N_CH-1:0]   req, cancel;
  logic [16*N_CH-1:0] req_load;
  logic [3*N_CH-1:0] req_ps;
  logic [N_CH-1:0]   done, req_err, pending;
  logic              busy, tmr_en, tmr_go, tmr_auto_load, tmr_write;
  logic [CH_W-1:0]   active_ch;
  logic [15:0]       tmr_load;
  logic [2:0]        tmr_ps;
  logic              tmr_int, tmr_go_clear;

  int checks = 0;
  int errors = 0;

  timer_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_load(req_load), .req_ps(req_ps),
    .cancel(cancel), .done(done), .req_err(req_err), .pending(pending),
    .busy(busy), .active_ch(active_ch), .tmr_load(tmr_load), .tmr_ps(tmr_ps),
    .tmr_en(tmr_en), .tmr_go(tmr_go), .tmr_auto_load(tmr_auto_load),
    .tmr_write(tmr_write), .tmr_int(tmr_int), .tmr_go_clear(tmr_go_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a CFG cycle: START, RUN (go_clear), WAIT (tmr_int rises); returns in the DONE cycle.
  task automatic complete_job();
    step();
    step();
    tmr_go_clear = 1'b1;
    step();
    tmr_go_clear = 1'b0;
    tmr_int = 1'b1;
    step();
    tmr_int = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++; if ({done, req_err, pending} !== 12'h000) begin errors++;
      $display("FAIL reset_vecs: got %h exp 000", {done, req_err, pending}); end
    checks++; if ({busy, tmr_en, tmr_go, tmr_write, tmr_auto_load} !== 5'b0) begin errors++;
      $display("FAIL reset_ctl: got %b exp 00000", {busy, tmr_en, tmr_go, tmr_write, tmr_auto_load}); end
    checks++; if ({active_ch, tmr_load, tmr_ps} !== 21'h0) begin errors++;
      $display("FAIL reset_cfg: got %h exp 0", {active_ch, tmr_load, tmr_ps}); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    req = 4'b0001; req_load[15:0] = 16'hFFF0; req_ps[2:0] = 3'b000;
    step();
    req = '0;
    checks++; if (pending !== 4'b0001 || tmr_write !== 1'b0) begin errors++;
      $display("FAIL single_capture: pending %b wr %b exp 0001 0", pending, tmr_write); end
    step();
    checks++; if (tmr_write !== 1'b1 || tmr_load !== 16'hFFF0 || tmr_ps !== 3'd0) begin errors++;
      $display("FAIL single_cfg: wr %b load %h ps %0d exp 1 fff0 0", tmr_write, tmr_load, tmr_ps); end
    checks++; if (tmr_en !== 1'b1 || busy !== 1'b1 || active_ch !== 2'd0 || pending !== 4'b0) begin errors++;
      $display("FAIL single_grant: en %b busy %b ch %0d pend %b exp 1 1 0 0000", tmr_en, busy, active_ch, pending); end
    step();
    checks++; if (tmr_go !== 1'b1 || tmr_write !== 1'b0) begin errors++;
      $display("FAIL single_start: go %b wr %b exp 1 0", tmr_go, tmr_write); end
    step();
    checks++; if (tmr_go !== 1'b1) begin errors++;
      $display("FAIL single_run_go: got %b exp 1", tmr_go); end
    tmr_go_clear = 1'b1;
    step();
    tmr_go_clear = 1'b0;
    checks++; if (tmr_go !== 1'b0 || done !== 4'b0) begin errors++;
      $display("FAIL single_wait: go %b done %b exp 0 0000", tmr_go, done); end
    step();
    tmr_int = 1'b1;
    step();
    checks++; if (done !== 4'b0001 || tmr_en !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL single_done: done %b en %b busy %b exp 0001 0 1", done, tmr_en, busy); end
    step();
    checks++; if (done !== 4'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL single_idle: done %b busy %b exp 0000 0", done, busy); end
    step();
    checks++; if (done !== 4'b0) begin errors++;
      $display("FAIL single_one_pulse: done %b exp 0000", done); end
    tmr_int = 1'b0;
    step();
  endtask

  // rr_ptr is 1 here: ch0 and ch1 both queued must grant ch1 first.
  task automatic test_duplicate();
    req = 4'b0011; req_load[15:0] = 16'hAAAA; req_load[31:16] = 16'h1111; req_ps[5:0] = 6'o53;
    step();
    req = 4'b0010; req_load[31:16] = 16'h2222; req_ps[5:3] = 3'd1;
    step();
    req = '0;
    checks++; if (req_err !== 4'b0010) begin errors++;
      $display("FAIL dup_err: got %b exp 0010", req_err); end
    checks++; if (active_ch !== 2'd1 || tmr_load !== 16'h1111 || tmr_ps !== 3'd5 || pending !== 4'b0001) begin errors++;
      $display("FAIL dup_grant: ch %0d load %h ps %0d pend %b exp 1 1111 5 0001", active_ch, tmr_load, tmr_ps, pending); end
    step();
    checks++; if (req_err !== 4'b0) begin errors++;
      $display("FAIL dup_err_once: got %b exp 0000", req_err); end
    step();
    tmr_go_clear = 1'b1;
    step();
    tmr_go_clear = 1'b0;
    tmr_int = 1'b1;
    step();
    tmr_int = 1'b0;
    checks++; if (done !== 4'b0010) begin errors++;
      $display("FAIL dup_done1: got %b exp 0010", done); end
    step();
    step();
    checks++; if (tmr_write !== 1'b1 || active_ch !== 2'd0 || tmr_load !== 16'hAAAA || tmr_ps !== 3'd3) begin errors++;
      $display("FAIL dup_b2b: wr %b ch %0d load %h ps %0d exp 1 0 aaaa 3", tmr_write, active_ch, tmr_load, tmr_ps); end
    complete_job();
    checks++; if (done !== 4'b0001) begin errors++;
      $display("FAIL dup_done0: got %b exp 0001", done); end
    step();
    // Single ch1 job moves rr_ptr to 2 for the round-robin test.
    req = 4'b0010; req_load[31:16] = 16'h0042;
    step();
    req = '0;
    step();
    checks++; if (active_ch !== 2'd1 || tmr_load !== 16'h0042) begin errors++;
      $display("FAIL dup_ch1_again: ch %0d load %h exp 1 0042", active_ch, tmr_load); end
    complete_job();
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ch  [4];
    logic [3:0]  exp_pnd [4];
    exp_ch  = '{2'd2, 2'd3, 2'd0, 2'd1};
    exp_pnd = '{4'b1011, 4'b0011, 4'b0010, 4'b0000};
    req = 4'b1111;
    req_load = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    step();
    req = '0;
    checks++; if (pending !== 4'b1111) begin errors++;
      $display("FAIL rr_pending: got %b exp 1111", pending); end
    step();
    for (int j = 0; j < 4; j++) begin
      checks++; if (tmr_write !== 1'b1 || active_ch !== exp_ch[j] || pending !== exp_pnd[j]
                    || tmr_load !== 16'h1000 * (exp_ch[j] + 16'd1)) begin errors++;
        $display("FAIL rr_grant%0d: wr %b ch %0d pend %b load %h exp ch %0d pend %b", j,
                 tmr_write, active_ch, pending, tmr_load, exp_ch[j], exp_pnd[j]); end
      complete_job();
      checks++; if (done !== (4'b0001 << exp_ch[j])) begin errors++;
        $display("FAIL rr_done%0d: got %b exp ch %0d", j, done, exp_ch[j]); end
      step();
      if (j < 3) step();
    end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rr_idle: busy %b exp 0", busy); end
  endtask

  task automatic test_cancel_active();
    req = 4'b0100; req_load[47:32] = 16'h5555;
    step();
    req = '0;
    step();
    checks++; if (active_ch !== 2'd2 || tmr_write !== 1'b1) begin errors++;
      $display("FAIL cancel_grant: ch %0d wr %b exp 2 1", active_ch, tmr_write); end
    step();
    step();
    tmr_go_clear = 1'b1;
    step();
    tmr_go_clear = 1'b0;
    req = 4'b1000; req_load[63:48] = 16'h7777;
    step();
    req = '0;
    checks++; if (pending !== 4'b1000) begin errors++;
      $display("FAIL cancel_pend3: got %b exp 1000", pending); end
    cancel = 4'b0100;
    step();
    cancel = '0;
    checks++; if (tmr_en !== 1'b0 || tmr_go !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin errors++;
      $display("FAIL cancel_idle: en %b go %b busy %b done %b exp 0 0 0 0000", tmr_en, tmr_go, busy, done); end
    step();
    checks++; if (tmr_write !== 1'b1 || active_ch !== 2'd3 || tmr_load !== 16'h7777 || done !== 4'b0) begin errors++;
      $display("FAIL cancel_next: wr %b ch %0d load %h done %b exp 1 3 7777 0000", tmr_write, active_ch, tmr_load, done); end
    complete_job();
    checks++; if (done !== 4'b1000) begin errors++;
      $display("FAIL cancel_done3: got %b exp 1000", done); end
    step();
  endtask

  task automatic test_simultaneous();
    req = 4'b0010; cancel = 4'b0010; req_load[31:16] = 16'h0BAD;
    step();
    req = '0; cancel = '0;
    checks++; if (pending !== 4'b0 || req_err !== 4'b0) begin errors++;
      $display("FAIL simul_drop: pend %b err %b exp 0000 0000", pending, req_err); end
    step();
    checks++; if (busy !== 1'b0 || tmr_write !== 1'b0) begin errors++;
      $display("FAIL simul_nogrant: busy %b wr %b exp 0 0", busy, tmr_write); end
  endtask

  // rr_ptr is 0 after the cancel test (last grant was ch3).
  task automatic test_reset_mid_run();
    req = 4'b0101; req_load[15:0] = 16'h1234; req_load[47:32] = 16'h9999;
    step();
    req = '0;
    step();
    step();
    step();
    checks++; if (active_ch !== 2'd0 || pending !== 4'b0100 || tmr_go !== 1'b1) begin errors++;
      $display("FAIL rst_run: ch %0d pend %b go %b exp 0 0100 1", active_ch, pending, tmr_go); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if ({done, req_err, pending, busy, tmr_en, tmr_go, tmr_write} !== 16'h0
                  || {active_ch, tmr_load, tmr_ps} !== 21'h0) begin errors++;
      $display("FAIL rst_mid: vec %h cfg %h exp 0 0", {done, req_err, pending, busy, tmr_en, tmr_go, tmr_write},
               {active_ch, tmr_load, tmr_ps}); end
    req = 4'b0001; req_load[15:0] = 16'h00FF; req_ps[2:0] = 3'd7;
    step();
    req = '0;
    checks++; if (done !== 4'b0 || pending !== 4'b0001) begin errors++;
      $display("FAIL rst_newreq: done %b pend %b exp 0000 0001", done, pending); end
    step();
    checks++; if (tmr_write !== 1'b1 || active_ch !== 2'd0 || tmr_load !== 16'h00FF || tmr_ps !== 3'd7) begin errors++;
      $display("FAIL rst_cfg: wr %b ch %0d load %h ps %0d exp 1 0 00ff 7", tmr_write, active_ch, tmr_load, tmr_ps); end
    complete_job();
    checks++; if (done !== 4'b0001) begin errors++;
      $display("FAIL rst_done: got %b exp 0001", done); end
    step();
    checks++; if (busy !== 1'b0 || done !== 4'b0) begin errors++;
      $display("FAIL rst_idle: busy %b done %b exp 0 0000", busy, done); end
  endtask

  initial begin
    rst = 1'b0; req = '0; cancel = '0; req_load = '0; req_ps = '0;
    tmr_int = 1'b0; tmr_go_clear = 1'b0;
    #1;
    test_reset();
    test_single();
    test_duplicate();
    test_round_robin();
    test_cancel_active();
    test_simultaneous();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
